// File: rtl/timer_pkg.sv
// Purpose: shared register map and bit positions for the APB timer peripheral.
// Latency: n/a (constants only).
// Backpressure: n/a.
package timer_pkg;

  // Word offsets decoded from PADDR[4:2]
  localparam logic [2:0] TIM_CR  = 3'd0;
  localparam logic [2:0] TIM_PSC = 3'd1;
  localparam logic [2:0] TIM_ARR = 3'd2;
  localparam logic [2:0] TIM_CNT = 3'd3;
  localparam logic [2:0] TIM_SR  = 3'd4;
  localparam logic [2:0] TIM_CCR = 3'd5;

  // Control register fields
  localparam int CR_EN   = 0;
  localparam int CR_OPM  = 1;
  localparam int CR_UIE  = 2;
  localparam int CR_CCIE = 3;
  localparam int CR_BITS = 4;

  // Status register fields (write-1-to-clear)
  localparam int SR_UIF  = 0;
  localparam int SR_CCIF = 1;
  localparam int SR_BITS = 2;

endpackage

// File: rtl/timer_core.sv
// Purpose: prescaler, up-counter with auto-reload, compare match and event pulses.
// Latency: events are combinational in the tick cycle; counter updates on the tick edge.
// Backpressure: none; a software CNT write overrides the tick update and restarts the prescaler.
module timer_core #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             opm_i,
  input  logic [PSC_W-1:0] psc_i,
  input  logic [CNT_W-1:0] arr_i,
  input  logic [CNT_W-1:0] ccr_i,
  input  logic             cnt_wr_i,
  input  logic [CNT_W-1:0] cnt_wdata_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             uif_set_o,
  output logic             ccif_set_o,
  output logic             opm_stop_o
);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             at_arr;

  // >= rather than == so that lowering PSC below the running count ticks
  // straight away instead of waiting for the prescaler to wrap.
  assign tick       = en_i & (psc_cnt_q >= psc_i);
  assign at_arr     = (cnt_q == arr_i);
  // Decisions use the pre-update counter value.
  assign uif_set_o  = tick & at_arr;
  assign ccif_set_o = tick & (cnt_q == ccr_i);
  assign opm_stop_o = uif_set_o & opm_i;
  assign cnt_o      = cnt_q;

  // Prescaler: held at zero while disabled, restarts on tick or CNT write
  always_comb begin
    psc_cnt_d = psc_cnt_q + PSC_W'(1);
    if (!en_i || cnt_wr_i || tick) begin
      psc_cnt_d = '0;
    end
  end

  // Counter: software write wins, otherwise reload at ARR or increment
  // (a value above ARR simply runs on and wraps naturally at 2^CNT_W).
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_wr_i) begin
      cnt_d = cnt_wdata_i;
    end else if (tick) begin
      cnt_d = at_arr ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer_periph.sv
// Purpose: APB completer wrapping timer_core with register file, W1C status and irq.
// Latency: one wait state per transfer; PREADY high in the second access cycle.
// Backpressure: PREADY never high on consecutive cycles; irq is registered (flag + 1 cycle).
module apb_timer_periph
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        timer_irq
);

  logic [CR_BITS-1:0] cr_q, cr_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [CNT_W-1:0]   arr_q, arr_d;
  logic [CNT_W-1:0]   ccr_q, ccr_d;
  logic [SR_BITS-1:0] sr_q, sr_d;
  logic [31:0]        prdata_q;
  logic               pready_q;
  logic               irq_q;

  logic [2:0]         reg_sel;
  logic               access;
  logic               wr_en;
  logic               rd_en;
  logic               cnt_wr;
  logic [31:0]        rdata;
  logic [CNT_W-1:0]   cnt;
  logic               uif_set;
  logic               ccif_set;
  logic               opm_stop;

  // Address bits outside the word index and unused data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  assign reg_sel = PADDR[4:2];
  // The first access cycle is the only one that acts; the PREADY cycle is inert.
  assign access  = PSEL & PENABLE & ~pready_q;
  assign wr_en   = access & PWRITE;
  assign rd_en   = access & ~PWRITE;
  assign cnt_wr  = wr_en & (reg_sel == TIM_CNT);

  timer_core #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) u_core (
    .clk_i       (PCLK),
    .rst_i       (PRESET),
    .en_i        (cr_q[CR_EN]),
    .opm_i       (cr_q[CR_OPM]),
    .psc_i       (psc_q),
    .arr_i       (arr_q),
    .ccr_i       (ccr_q),
    .cnt_wr_i    (cnt_wr),
    .cnt_wdata_i (PWDATA[CNT_W-1:0]),
    .cnt_o       (cnt),
    .uif_set_o   (uif_set),
    .ccif_set_o  (ccif_set),
    .opm_stop_o  (opm_stop)
  );

  // Register next-state: software writes first, then hardware events on top
  always_comb begin
    cr_d  = cr_q;
    psc_d = psc_q;
    arr_d = arr_q;
    ccr_d = ccr_q;
    sr_d  = sr_q;
    if (wr_en) begin
      case (reg_sel)
        TIM_CR:  cr_d  = PWDATA[CR_BITS-1:0];
        TIM_PSC: psc_d = PWDATA[PSC_W-1:0];
        TIM_ARR: arr_d = PWDATA[CNT_W-1:0];
        TIM_CCR: ccr_d = PWDATA[CNT_W-1:0];
        TIM_SR:  sr_d  = sr_q & ~PWDATA[SR_BITS-1:0];
        default: ;
      endcase
    end
    // One-pulse stop; a CR write on the same edge carries software's intent.
    if (opm_stop && !(wr_en && (reg_sel == TIM_CR))) begin
      cr_d[CR_EN] = 1'b0;
    end
    // Hardware set beats a simultaneous W1C so no event is lost.
    if (uif_set) begin
      sr_d[SR_UIF] = 1'b1;
    end
    if (ccif_set) begin
      sr_d[SR_CCIF] = 1'b1;
    end
  end

  // Read mux; undefined bits and unmapped offsets return zero
  always_comb begin
    rdata = '0;
    case (reg_sel)
      TIM_CR:  rdata[CR_BITS-1:0] = cr_q;
      TIM_PSC: rdata[PSC_W-1:0]   = psc_q;
      TIM_ARR: rdata[CNT_W-1:0]   = arr_q;
      TIM_CNT: rdata[CNT_W-1:0]   = cnt;
      TIM_SR:  rdata[SR_BITS-1:0] = sr_q;
      TIM_CCR: rdata[CNT_W-1:0]   = ccr_q;
      default: ;
    endcase
  end

  // Register file, handshake, read capture and interrupt
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cr_q     <= '0;
      psc_q    <= '0;
      arr_q    <= '0;
      ccr_q    <= '0;
      sr_q     <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cr_q     <= cr_d;
      psc_q    <= psc_d;
      arr_q    <= arr_d;
      ccr_q    <= ccr_d;
      sr_q     <= sr_d;
      pready_q <= access;
      if (rd_en) begin
        prdata_q <= rdata;
      end
      irq_q <= (sr_q[SR_UIF] & cr_q[CR_UIE]) | (sr_q[SR_CCIF] & cr_q[CR_CCIE]);
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Purpose: directed self-checking bench for apb_timer_periph with a read scoreboard.
// Latency: expects PREADY exactly one cycle after the first access cycle.
// Backpressure: every PREADY wait is bounded; an expired bound is a failed check.
module tb_apb_timer_periph;

  localparam logic [31:0] A_CR  = 32'h00;
  localparam logic [31:0] A_PSC = 32'h04;
  localparam logic [31:0] A_ARR = 32'h08;
  localparam logic [31:0] A_CNT = 32'h0C;
  localparam logic [31:0] A_SR  = 32'h10;
  localparam logic [31:0] A_CCR = 32'h14;
  localparam logic [31:0] A_R18 = 32'h18;
  localparam logic [31:0] A_R1C = 32'h1C;

  logic        PCLK, PRESET, PWRITE, PENABLE, PSEL;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, timer_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_commit = 0;
  int irq_rise_cyc = -1;
  bit irq_seen = 0;
  bit irq_fell = 0;
  logic [31:0] exp_q[$];

  apb_timer_periph dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .timer_irq (timer_irq)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Edge counter used as the time base for the expected-value model
  always @(posedge PCLK) cyc = cyc + 1;

  // Interrupt monitor: first rising cycle and any later drop
  always @(negedge PCLK) begin
    if (timer_irq === 1'b1 && !irq_seen) begin
      irq_seen = 1;
      irq_rise_cyc = cyc;
    end
    if (irq_seen && timer_irq !== 1'b1) irq_fell = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic reset_irq_monitor();
    irq_seen = 0;
    irq_fell = 0;
    irq_rise_cyc = -1;
  endtask

  // One APB transfer, entered #1 after a clock edge. The write/read commits
  // on the second edge (recorded in last_commit); reads pop the scoreboard.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
    int nwait;
    bit got_rdy;
    logic [31:0] exp;
    last_commit = cyc + 2;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    check({tag, " pready-low-1st-access"}, 32'(PREADY), 32'd0);
    nwait = 0;
    got_rdy = 0;
    while (!got_rdy && nwait < 8) begin
      @(posedge PCLK); #1;
      nwait++;
      if (PREADY === 1'b1) got_rdy = 1;
    end
    if (!got_rdy) check({tag, " pready-timeout"}, 32'(got_rdy), 32'd1);
    else check({tag, " pready-wait-cycles"}, 32'(nwait), 32'd1);
    if (!wr) begin
      exp = exp_q.pop_front();
      if (got_rdy) check(tag, PRDATA, exp);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check({tag, " pready-single-cycle"}, 32'(PREADY), 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
    apb_xfer(1'b1, addr, data, tag);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    apb_xfer(1'b0, addr, 32'd0, tag);
  endtask

  // Free-running counter value read at capture edge c, enabled at edge s
  function automatic logic [31:0] free_cnt(int c, int s, int p, int a);
    int k;
    k = (c - 1 - s) / (p + 1);
    return 32'(k % (a + 1));
  endfunction

  // One-pulse run with PSC=0, ARR=9, CCR=5 enabled at edge s
  function automatic logic [31:0] opm_cnt(int c, int s);
    int k;
    k = c - 1 - s;
    return (k >= 10) ? 32'd0 : 32'(k);
  endfunction

  function automatic logic [31:0] opm_sr(int c, int s);
    int k;
    k = c - 1 - s;
    return ((k >= 6) ? 32'h2 : 32'h0) | ((k >= 10) ? 32'h1 : 32'h0);
  endfunction

  function automatic logic [31:0] opm_cr(int c, int s);
    return ((c - 1 - s) >= 10) ? 32'hA : 32'hB;
  endfunction

  initial begin
    int s;
    int f;
    int w;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (2) @(posedge PCLK);
    #1;
    check("reset PREADY", 32'(PREADY), 32'd0);
    check("reset PRDATA", PRDATA, 32'd0);
    check("reset irq", 32'(timer_irq), 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Reset values of every register
    rd(A_CR,  32'd0, "rst CR");
    rd(A_PSC, 32'd0, "rst PSC");
    rd(A_ARR, 32'd0, "rst ARR");
    rd(A_CNT, 32'd0, "rst CNT");
    rd(A_SR,  32'd0, "rst SR");
    rd(A_CCR, 32'd0, "rst CCR");

    // Prescaled auto-reload: PSC=3, ARR=4, UIE on
    wr(A_CCR, 32'hFFFF_FFFF, "p2 ccr");
    wr(A_PSC, 32'd3, "p2 psc");
    wr(A_ARR, 32'd4, "p2 arr");
    reset_irq_monitor();
    wr(A_CR, 32'h5, "p2 cr");
    s = last_commit;
    for (int i = 0; i < 7; i++) rd(A_CNT, free_cnt(cyc + 2, s, 3, 4), "p2 cnt");
    wr(A_CR, 32'h0, "p2 stop");
    f = last_commit;
    rd(A_SR, 32'h1, "p2 sr uif");
    check("p2 irq rise cycle", 32'(irq_rise_cyc), 32'(s + 21));
    rd(A_CNT, free_cnt(f + 1, s, 3, 4), "p2 cnt frozen");
    wr(A_SR, 32'h1, "p2 sr w1c");
    rd(A_SR, 32'h0, "p2 sr cleared");

    // One-pulse with compare: PSC=0, ARR=9, CCR=5, CR=EN|OPM|CCIE
    wr(A_PSC, 32'd0, "p3 psc");
    wr(A_ARR, 32'd9, "p3 arr");
    wr(A_CCR, 32'd5, "p3 ccr");
    wr(A_CNT, 32'd0, "p3 cnt0");
    reset_irq_monitor();
    wr(A_CR, 32'hB, "p3 cr");
    s = last_commit;
    rd(A_CNT, opm_cnt(cyc + 2, s), "p3 cnt a");
    rd(A_CNT, opm_cnt(cyc + 2, s), "p3 cnt b");
    rd(A_SR,  opm_sr(cyc + 2, s),  "p3 sr ccif");
    rd(A_CR,  opm_cr(cyc + 2, s),  "p3 cr en cleared");
    rd(A_CNT, opm_cnt(cyc + 2, s), "p3 cnt held");
    rd(A_SR,  opm_sr(cyc + 2, s),  "p3 sr both");
    check("p3 irq rise cycle", 32'(irq_rise_cyc), 32'(s + 7));
    wr(A_CR, 32'h0, "p3 cr off");
    wr(A_SR, 32'h3, "p3 sr clr");

    // W1C colliding with hardware set: ARR=0, PSC=0, UIE
    wr(A_ARR, 32'd0, "p4 arr");
    wr(A_CNT, 32'd0, "p4 cnt0");
    reset_irq_monitor();
    wr(A_CR, 32'h5, "p4 cr");
    s = last_commit;
    wr(A_SR, 32'h1, "p4 sr w1c race");
    rd(A_SR, 32'h1, "p4 sr uif kept");
    check("p4 irq rise cycle", 32'(irq_rise_cyc), 32'(s + 2));
    check("p4 irq never dropped", 32'(irq_fell), 32'd0);
    check("p4 irq level", 32'(timer_irq), 32'd1);
    wr(A_CR, 32'h0, "p4 cr off");
    wr(A_SR, 32'h1, "p4 sr clr");
    rd(A_SR, 32'h0, "p4 sr cleared");

    // CNT write on a tick edge, then with a prescaler restart
    wr(A_ARR, 32'hFFFF_FFFF, "p5 arr");
    wr(A_CCR, 32'hFFFF_FFFF, "p5 ccr");
    wr(A_CR, 32'h1, "p5 cr");
    wr(A_CNT, 32'h100, "p5 cnt wr");
    w = last_commit;
    for (int i = 0; i < 2; i++) rd(A_CNT, 32'h100 + 32'(cyc + 1 - w), "p5 cnt run");
    wr(A_PSC, 32'd3, "p5 psc3");
    wr(A_CNT, 32'h200, "p5 cnt wr2");
    w = last_commit;
    for (int i = 0; i < 2; i++) rd(A_CNT, 32'h200 + 32'((cyc + 1 - w) / 4), "p5 cnt psc");
    wr(A_CR, 32'h0, "p5 cr off");
    wr(A_R18, 32'hDEAD_BEEF, "p5 wr 0x18");
    rd(A_R18, 32'd0, "p5 rd 0x18");
    rd(A_R1C, 32'd0, "p5 rd 0x1C");
    rd(A_PSC, 32'd3, "p5 psc intact");
    rd(A_CR,  32'd0, "p5 cr intact");

    // Reset during the access phase of an ARR write
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_ARR; PWDATA = 32'h55; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1 check("p6 pready in reset", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    check("p6 pready held low", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    rd(A_ARR, 32'd0, "p6 arr after reset");

    // Reset while PREADY is high drops it without waiting for a clock
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_PSC; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("p6 pready before reset", 32'(PREADY), 32'd1);
    #2 PRESET = 1'b1;
    #1 check("p6 pready async drop", 32'(PREADY), 32'd0);
    check("p6 prdata async clear", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
